// File: rtl/am2909_seq.sv
// ============================================================================
// Module      : am2909_seq
// Description : Am2909-style microprogram sequencer slice. It selects the next
//               microaddress from uPC, AR, the stack top or direct input, and
//               holds a 4-deep push/pop stack. Defining AM2909_STKFLAG_EN adds
//               a saturating depth counter and the stk_full/stk_empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module am2909_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr_,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] r,
    input  logic [1:0]       s,
    input  logic             zero_,
    input  logic             re_,
    input  logic             fe_,
    input  logic             pup,
    input  logic             cn,
`ifdef AM2909_STKFLAG_EN
    output logic             stk_full,
    output logic             stk_empty,
`endif
    output logic [WIDTH-1:0] y,
    output logic             cn4
);

    localparam logic [1:0] c_SEL_UPC = 2'b00;
    localparam logic [1:0] c_SEL_AR  = 2'b01;
    localparam logic [1:0] c_SEL_STK = 2'b10;

    logic [WIDTH-1:0] r_upc;
    logic [WIDTH-1:0] r_ar;
    logic [1:0]       r_sp;
    logic [WIDTH-1:0] r_stk [4];

    logic [WIDTH-1:0] w_src;
    logic [WIDTH-1:0] w_upc_next;
    logic [1:0]       w_sp_inc;
    logic [1:0]       w_sp_dec;

    always_comb begin
        w_src = d;
        case (s)
            c_SEL_UPC: w_src = r_upc;
            c_SEL_AR:  w_src = r_ar;
            c_SEL_STK: w_src = r_stk[r_sp];
            default:   w_src = d;
        endcase
    end

    // OR-mask first, then the zero force overrides everything.
    assign y          = zero_ ? (w_src | r) : '0;
    assign cn4        = cn & (&y);
    assign w_upc_next = y + {{(WIDTH-1){1'b0}}, cn};
    assign w_sp_inc   = r_sp + 2'd1;
    assign w_sp_dec   = r_sp - 2'd1;

    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            r_upc <= '0;
            r_ar  <= '0;
            r_sp  <= '0;
            for (int i = 0; i < 4; i++) begin
                r_stk[i] <= '0;
            end
        end else begin
            r_upc <= w_upc_next;
            if (!re_) begin
                r_ar <= d;
            end
            if (!fe_) begin
                if (pup) begin
                    r_sp           <= w_sp_inc;
                    r_stk[w_sp_inc] <= r_upc;
                end else begin
                    r_sp <= w_sp_dec;
                end
            end
        end
    end

`ifdef AM2909_STKFLAG_EN
    // Depth saturates at both ends while the pointer itself keeps wrapping.
    logic [2:0] r_depth;

    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            r_depth <= 3'd0;
        end else if (!fe_) begin
            if (pup) begin
                if (r_depth != 3'd4) begin
                    r_depth <= r_depth + 3'd1;
                end
            end else if (r_depth != 3'd0) begin
                r_depth <= r_depth - 3'd1;
            end
        end
    end

    assign stk_full  = (r_depth == 3'd4);
    assign stk_empty = (r_depth == 3'd0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_am2909_seq.sv
// ============================================================================
// Module      : tb_am2909_seq
// Description : Self-checking bench for am2909_seq: directed scenarios plus
//               randomized cycles compared against an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_am2909_seq;

    localparam int WIDTH = 4;
    localparam int MODV  = 16;

    logic             clk = 1'b0;
    logic             clr_ = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic [WIDTH-1:0] r = '0;
    logic [1:0]       s = '0;
    logic             zero_ = 1'b1;
    logic             re_ = 1'b1;
    logic             fe_ = 1'b1;
    logic             pup = 1'b0;
    logic             cn = 1'b0;
    logic [WIDTH-1:0] y;
    logic             cn4;
`ifdef AM2909_STKFLAG_EN
    logic             stk_full;
    logic             stk_empty;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: plain integers, stack as a circular list of words.
    int m_upc, m_ar, m_sp, m_depth;
    int m_stk [4];

    am2909_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .clr_  (clr_),
        .d     (d),
        .r     (r),
        .s     (s),
        .zero_ (zero_),
        .re_   (re_),
        .fe_   (fe_),
        .pup   (pup),
        .cn    (cn),
`ifdef AM2909_STKFLAG_EN
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
`endif
        .y     (y),
        .cn4   (cn4)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d exp %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_y();
        int src;
        case (int'(s))
            0:       src = m_upc;
            1:       src = m_ar;
            2:       src = m_stk[m_sp];
            default: src = int'(d);
        endcase
        return zero_ ? (src | int'(r)) : 0;
    endfunction

    task automatic check_outputs(input string tag);
        int ey;
        ey = exp_y();
        chk({tag, ".y"}, int'(y), ey);
        chk({tag, ".cn4"}, int'(cn4), (cn && ey == MODV - 1) ? 1 : 0);
`ifdef AM2909_STKFLAG_EN
        chk({tag, ".full"}, int'(stk_full), (m_depth == 4) ? 1 : 0);
        chk({tag, ".empty"}, int'(stk_empty), (m_depth == 0) ? 1 : 0);
`endif
    endtask

    task automatic model_reset();
        m_upc = 0; m_ar = 0; m_sp = 0; m_depth = 0;
        for (int i = 0; i < 4; i++) m_stk[i] = 0;
    endtask

    // Apply inputs just after a falling edge and check the combinational result.
    task automatic drive(input int ts, input int td, input int tr, input bit tz,
                         input bit tre, input bit tfe, input bit tpup, input bit tcn);
        s = ts[1:0]; d = td[3:0]; r = tr[3:0];
        zero_ = tz; re_ = tre; fe_ = tfe; pup = tpup; cn = tcn;
        #1;
        check_outputs("drv");
    endtask

    task automatic tick();
        int ey;
        int old_upc;
        ey = exp_y();
        old_upc = m_upc;
        @(posedge clk);
        m_upc = (ey + int'(cn)) % MODV;
        if (!re_) m_ar = int'(d);
        if (!fe_) begin
            if (pup) begin
                m_sp = (m_sp + 1) % 4;
                m_stk[m_sp] = old_upc;
                if (m_depth < 4) m_depth++;
            end else begin
                m_sp = (m_sp + 3) % 4;
                if (m_depth > 0) m_depth--;
            end
        end
        @(negedge clk);
    endtask

    // Asserted mid-cycle; clearing must be immediate and survive a clock edge.
    task automatic do_reset();
        clr_ = 1'b0;
        model_reset();
        #1;
        check_outputs("rst_async");
        @(posedge clk);
        #1;
        check_outputs("rst_hold");
        @(negedge clk);
        clr_ = 1'b1;
    endtask

    task automatic expect_y(input string tag, input int v);
        chk(tag, int'(y), v);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        // Reset state: s=00, r=0, zero_=1 gives y=0.
        drive(0, 0, 0, 1, 1, 1, 0, 1);
        expect_y("reset_y", 0);
        do_reset();

        // Incrementing uPC: 0..15 then wrap to 0, cn4 only at 15.
        for (int k = 0; k < 17; k++) begin
            drive(0, 0, 0, 1, 1, 1, 0, 1);
            expect_y("count", k % 16);
            chk("count_cn4", int'(cn4), (k == 15) ? 1 : 0);
            tick();
        end

        // AR load then OR-mask, then zero force.
        drive(3, 9, 0, 1, 0, 1, 0, 0);
        tick();
        drive(1, 0, 6, 1, 1, 1, 0, 0);
        expect_y("ar_or", 15);
        drive(1, 0, 6, 0, 1, 1, 0, 0);
        expect_y("ar_zero", 0);
        tick();

        // Push uPC values 3,5,7,9 then pop them back from the top.
        do_reset();
        drive(3, 3, 0, 1, 1, 1, 0, 0); tick();
        drive(3, 5, 0, 1, 1, 0, 1, 0); tick();
        drive(3, 7, 0, 1, 1, 0, 1, 0); tick();
        drive(3, 9, 0, 1, 1, 0, 1, 0); tick();
        drive(3, 0, 0, 1, 1, 0, 1, 0); tick();
        drive(2, 0, 0, 1, 1, 0, 0, 0); expect_y("pop9", 9); tick();
        drive(2, 0, 0, 1, 1, 0, 0, 0); expect_y("pop7", 7); tick();
        drive(2, 0, 0, 1, 1, 0, 0, 0); expect_y("pop5", 5); tick();
        drive(2, 0, 0, 1, 1, 0, 0, 0); expect_y("pop3", 3); tick();

        // Five pushes overflow: oldest entry is overwritten.
        do_reset();
        drive(3, 1, 0, 1, 1, 1, 0, 0); tick();
        for (int k = 2; k <= 6; k++) begin
            drive(3, k % 6, 0, 1, 1, 0, 1, 0);
            tick();
        end
`ifdef AM2909_STKFLAG_EN
        chk("full_after5", int'(stk_full), 1);
`endif
        for (int k = 5; k >= 2; k--) begin
            drive(2, 0, 0, 1, 1, 0, 0, 0);
            expect_y("ovf_pop", k);
            tick();
        end

        // Stack-top select together with push: old top now, new top next cycle.
        do_reset();
        drive(3, 6, 0, 1, 1, 1, 0, 0); tick();
        drive(3, 2, 0, 1, 1, 0, 1, 0); tick();
        drive(2, 0, 0, 1, 1, 0, 1, 0); expect_y("same_cyc_pre", 6); tick();
        drive(2, 0, 0, 1, 1, 1, 0, 0); expect_y("same_cyc_post", 2);
        do_reset();
        expect_y("clr_mid", 0);
        drive(2, 0, 0, 1, 1, 1, 0, 0); expect_y("clr_stack", 0);
        tick();

        // Randomized traffic with occasional asynchronous clears.
        for (int n = 0; n < 400; n++) begin
            drive(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0,
                  ($urandom_range(0, 7) != 0), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                  $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) do_reset();
            else tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
